// File: rtl/riscv_instr_encoder.sv
// RV32I instruction encoder that range-checks symbolic instructions, packs them
// into machine words and writes them to consecutive instruction-memory slots.
module riscv_instr_encoder #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 64,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  restart,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            op,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [31:0]           imm,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic [ADDR_WIDTH-1:0] count,
    output logic                  done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ENCODE = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [2:0] F_R = 3'd0;
    localparam logic [2:0] F_I = 3'd1;
    localparam logic [2:0] F_S = 3'd2;
    localparam logic [2:0] F_B = 3'd3;
    localparam logic [2:0] F_J = 3'd4;
    localparam logic [2:0] F_U = 3'd5;

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    logic [1:0]            state;
    logic                  started;
    logic [4:0]            op_q, rd_q, rs1_q, rs2_q;
    logic [31:0]           imm_q;
    logic [31:0]           word_q;
    logic [1:0]            code_q;
    logic [ADDR_WIDTH-1:0] ptr;

    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        legal;
    logic        in_range;
    logic        aligned;
    logic [1:0]  code;
    logic [31:0] word;

    // started keeps in_ready low for the first cycle after reset is released
    assign in_ready = started && (state == S_IDLE) && !restart;

    always_comb begin
        fmt    = F_R;
        opcode = 7'b0000000;
        f3     = 3'b000;
        f7     = 7'b0000000;
        legal  = 1'b1;
        case (op_q)
            5'd0:  begin fmt = F_R; opcode = 7'b0110011; f3 = 3'b000; end
            5'd1:  begin fmt = F_R; opcode = 7'b0110011; f3 = 3'b000; f7 = 7'b0100000; end
            5'd2:  begin fmt = F_R; opcode = 7'b0110011; f3 = 3'b111; end
            5'd3:  begin fmt = F_R; opcode = 7'b0110011; f3 = 3'b110; end
            5'd4:  begin fmt = F_R; opcode = 7'b0110011; f3 = 3'b010; end
            5'd5:  begin fmt = F_R; opcode = 7'b0110011; f3 = 3'b011; end
            5'd6:  begin fmt = F_I; opcode = 7'b0010011; f3 = 3'b000; end
            5'd7:  begin fmt = F_I; opcode = 7'b0010011; f3 = 3'b100; end
            5'd8:  begin fmt = F_I; opcode = 7'b0010011; f3 = 3'b110; end
            5'd9:  begin fmt = F_I; opcode = 7'b0010011; f3 = 3'b010; end
            5'd10: begin fmt = F_I; opcode = 7'b0010011; f3 = 3'b011; end
            5'd11: begin fmt = F_I; opcode = 7'b0000011; f3 = 3'b010; end
            5'd12: begin fmt = F_I; opcode = 7'b1100111; f3 = 3'b000; end
            5'd13: begin fmt = F_S; opcode = 7'b0100011; f3 = 3'b010; end
            5'd14: begin fmt = F_B; opcode = 7'b1100011; f3 = 3'b000; end
            5'd15: begin fmt = F_B; opcode = 7'b1100011; f3 = 3'b001; end
            5'd16: begin fmt = F_B; opcode = 7'b1100011; f3 = 3'b100; end
            5'd17: begin fmt = F_B; opcode = 7'b1100011; f3 = 3'b101; end
            5'd18: begin fmt = F_J; opcode = 7'b1101111; end
            5'd19: begin fmt = F_U; opcode = 7'b0110111; end
            default: legal = 1'b0;
        endcase
    end

    // A signed immediate fits in N bits when every bit from N-1 upward matches
    always_comb begin
        in_range = 1'b1;
        aligned  = 1'b1;
        case (fmt)
            F_I, F_S: in_range = (&imm_q[31:11]) || !(|imm_q[31:11]);
            F_B:      in_range = (&imm_q[31:12]) || !(|imm_q[31:12]);
            F_J:      in_range = (&imm_q[31:20]) || !(|imm_q[31:20]);
            F_U:      in_range = !(|imm_q[11:0]);
            default:  in_range = 1'b1;
        endcase
        if (fmt == F_B || fmt == F_J)
            aligned = !imm_q[0];
        if (!legal)
            code = 2'b01;
        else if (!in_range)
            code = 2'b10;
        else if (!aligned)
            code = 2'b11;
        else
            code = 2'b00;
    end

    always_comb begin
        case (fmt)
            F_R:     word = {f7, rs2_q, rs1_q, f3, rd_q, opcode};
            F_I:     word = {imm_q[11:0], rs1_q, f3, rd_q, opcode};
            F_S:     word = {imm_q[11:5], rs2_q, rs1_q, f3, imm_q[4:0], opcode};
            F_B:     word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3,
                             imm_q[4:1], imm_q[11], opcode};
            F_J:     word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12],
                             rd_q, opcode};
            F_U:     word = {imm_q[31:12], rd_q, opcode};
            default: word = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            started    <= 1'b0;
            op_q       <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
            word_q     <= '0;
            code_q     <= '0;
            ptr        <= BASE;
            count      <= '0;
            done       <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            err        <= 1'b0;
            err_code   <= '0;
        end else begin
            started <= 1'b1;
            imem_we <= 1'b0;
            err     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (restart) begin
                        ptr   <= BASE;
                        count <= '0;
                    end else if (in_valid && in_ready) begin
                        op_q  <= op;
                        rd_q  <= rd;
                        rs1_q <= rs1;
                        rs2_q <= rs2;
                        imm_q <= imm;
                        state <= S_ENCODE;
                    end
                end
                S_ENCODE: begin
                    word_q <= word;
                    code_q <= code;
                    state  <= S_WRITE;
                end
                S_WRITE: begin
                    if (code_q == 2'b00) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= ptr;
                        imem_wdata <= word_q;
                        ptr        <= ptr + STEP;
                        count      <= count + ADDR_WIDTH'(1);
                        if (count == LAST) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        err      <= 1'b1;
                        err_code <= code_q;
                        state    <= S_IDLE;
                    end
                end
                S_DONE: begin
                    if (restart) begin
                        ptr   <= BASE;
                        count <= '0;
                        done  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_instr_encoder.sv
// Directed bench for riscv_instr_encoder: an arithmetic reference encoder and a
// queue of expected write/error pulses checked on every falling edge.
module tb_riscv_instr_encoder;

    localparam int AW    = 8;
    localparam int DEPTH = 4;
    localparam int BASE  = 16;

    localparam logic [31:0] OPC [20] = '{
        32'h33, 32'h33, 32'h33, 32'h33, 32'h33, 32'h33,
        32'h13, 32'h13, 32'h13, 32'h13, 32'h13,
        32'h03, 32'h67, 32'h23,
        32'h63, 32'h63, 32'h63, 32'h63,
        32'h6F, 32'h37
    };
    localparam logic [31:0] F3 [20] = '{
        32'd0, 32'd0, 32'd7, 32'd6, 32'd2, 32'd3,
        32'd0, 32'd4, 32'd6, 32'd2, 32'd3,
        32'd2, 32'd0, 32'd2,
        32'd0, 32'd1, 32'd4, 32'd5,
        32'd0, 32'd0
    };

    logic          clk = 1'b0;
    logic          rst;
    logic          restart;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    op, rd, rs1, rs2;
    logic [31:0]   imm;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          err;
    logic [1:0]    err_code;
    logic [AW-1:0] count;
    logic          done;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  code;
        logic        has_lit;
        logic [31:0] lit;
        int          cnt;
        longint      due;
    } exp_t;

    exp_t q[$];
    int passed = 0;
    int total  = 0;
    int m_ptr  = BASE;
    int m_cnt  = 0;

    riscv_instr_encoder #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .restart(restart), .in_valid(in_valid),
        .in_ready(in_ready), .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .err(err), .err_code(err_code), .count(count), .done(done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act === want)
            passed++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
    endtask

    function automatic logic [31:0] field(input logic [31:0] u, input int lo, input int n);
        return (u >> lo) & ((32'd1 << n) - 32'd1);
    endfunction

    // Reference encoder: classify by op number, check the numeric range, then sum shifted fields
    function automatic void modelEncode(input int opn, input int r, input int s1, input int s2,
                                        input int immv, output logic [31:0] w, output logic [1:0] c);
        int kind;
        bit ok;
        logic [31:0] u, base;
        u = immv;
        w = 32'h0;
        c = 2'b00;
        if (opn > 19) begin
            c = 2'b01;
            return;
        end
        kind = (opn <= 5) ? 0 : (opn <= 12) ? 1 : (opn == 13) ? 2 :
               (opn <= 17) ? 3 : (opn == 18) ? 4 : 5;
        case (kind)
            1, 2:    ok = (immv >= -2048) && (immv <= 2047);
            3:       ok = (immv >= -4096) && (immv <= 4095);
            4:       ok = (immv >= -(1 << 20)) && (immv <= (1 << 20) - 1);
            5:       ok = (immv % 4096) == 0;
            default: ok = 1'b1;
        endcase
        if (!ok)
            c = 2'b10;
        else if ((kind == 3 || kind == 4) && (immv % 2) != 0)
            c = 2'b11;
        base = OPC[opn] + (F3[opn] << 12);
        case (kind)
            0: w = base + (32'(r) << 7) + (32'(s1) << 15) + (32'(s2) << 20)
                 + ((opn == 1) ? (32'd32 << 25) : 32'd0);
            1: w = base + (32'(r) << 7) + (32'(s1) << 15) + (field(u, 0, 12) << 20);
            2: w = base + (field(u, 0, 5) << 7) + (32'(s1) << 15) + (32'(s2) << 20)
                 + (field(u, 5, 7) << 25);
            3: w = base + (field(u, 11, 1) << 7) + (field(u, 1, 4) << 8) + (32'(s1) << 15)
                 + (32'(s2) << 20) + (field(u, 5, 6) << 25) + (field(u, 12, 1) << 31);
            4: w = OPC[opn] + (32'(r) << 7) + (field(u, 12, 8) << 12) + (field(u, 11, 1) << 20)
                 + (field(u, 1, 10) << 21) + (field(u, 20, 1) << 31);
            default: w = OPC[opn] + (32'(r) << 7) + (field(u, 12, 20) << 12);
        endcase
    endfunction

    task automatic applyStimulus(input int opn, input int r, input int s1, input int s2,
                                 input int immv, input bit has_lit, input logic [31:0] lit);
        exp_t e;
        logic [31:0] w;
        logic [1:0]  c;
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 32'(in_ready), 32'd1);
            return;
        end
        op       = 5'(opn);
        rd       = 5'(r);
        rs1      = 5'(s1);
        rs2      = 5'(s2);
        imm      = immv;
        in_valid = 1'b1;
        @(posedge clk);
        modelEncode(opn, r, s1, s2, immv, w, c);
        e.we      = (c == 2'b00);
        e.addr    = m_ptr;
        e.wdata   = w;
        e.code    = c;
        e.has_lit = has_lit;
        e.lit     = lit;
        e.due     = $time + 25;
        if (c == 2'b00) begin
            m_ptr += 4;
            m_cnt += 1;
        end
        e.cnt = m_cnt;
        q.push_back(e);
        #1 in_valid = 1'b0;
    endtask

    task automatic doRestart();
        int n = 0;
        while (q.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        restart = 1'b1;
        #1 checkOutput("ready_low_during_restart", 32'(in_ready), 32'd0);
        @(negedge clk);
        restart = 1'b0;
        m_ptr   = BASE;
        m_cnt   = 0;
        #1;
        checkOutput("count_after_restart", 32'(count), 32'd0);
        checkOutput("done_after_restart", 32'(done), 32'd0);
    endtask

    task automatic issue(input int opn, input int r, input int s1, input int s2, input int immv);
        if (m_cnt == DEPTH)
            doRestart();
        applyStimulus(opn, r, s1, s2, immv, 1'b0, 32'h0);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (imem_we || err) begin
                if (q.size() == 0) begin
                    checkOutput("unexpected_pulse", {30'b0, imem_we, err}, 32'd0);
                end else begin
                    e = q.pop_front();
                    checkOutput("pulse_time", 32'($time), 32'(e.due));
                    checkOutput("imem_we", 32'(imem_we), 32'(e.we));
                    checkOutput("err", 32'(err), 32'(!e.we));
                    if (e.we) begin
                        checkOutput("imem_addr", 32'(imem_addr), e.addr);
                        checkOutput("imem_wdata", imem_wdata, e.wdata);
                        if (e.has_lit)
                            checkOutput("imem_wdata_literal", imem_wdata, e.lit);
                    end else begin
                        checkOutput("err_code", 32'(err_code), 32'(e.code));
                        if (e.has_lit)
                            checkOutput("err_code_literal", 32'(err_code), e.lit);
                    end
                    checkOutput("count", 32'(count), 32'(e.cnt));
                    checkOutput("done", 32'(done), 32'(e.cnt == DEPTH));
                    checkOutput("in_ready_after_pulse", 32'(in_ready), 32'(e.cnt != DEPTH));
                end
            end else if (q.size() > 0 && q[0].due < $time) begin
                e = q.pop_front();
                checkOutput("missing_pulse", 32'(imem_we || err), 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        rst      = 1'b1;
        restart  = 1'b0;
        in_valid = 1'b0;
        op       = '0;
        rd       = '0;
        rs1      = '0;
        rs2      = '0;
        imm      = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset_imem_we", 32'(imem_we), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_err_code", 32'(err_code), 32'd0);
        checkOutput("reset_imem_addr", 32'(imem_addr), 32'd0);
        checkOutput("reset_imem_wdata", imem_wdata, 32'd0);
        checkOutput("reset_count", 32'(count), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("in_ready_after_reset", 32'(in_ready), 32'd1);

        applyStimulus(0, 3, 1, 2, 0, 1'b1, 32'h002081B3);
        applyStimulus(6, 1, 0, 0, -1, 1'b1, 32'hFFF00093);
        applyStimulus(13, 0, 2, 5, 8, 1'b1, 32'h00512423);
        applyStimulus(19, 5, 0, 0, 32'h12345000, 1'b1, 32'h123452B7);
        drain();

        // A held request while full must not be taken
        in_valid = 1'b1;
        op       = 5'd0;
        repeat (5) @(negedge clk);
        checkOutput("full_in_ready", 32'(in_ready), 32'd0);
        checkOutput("full_count", 32'(count), 32'(DEPTH));
        checkOutput("full_done", 32'(done), 32'd1);
        in_valid = 1'b0;

        doRestart();
        applyStimulus(14, 0, 1, 2, -4, 1'b1, 32'hFE208EE3);
        applyStimulus(18, 1, 0, 0, 8, 1'b1, 32'h008000EF);
        applyStimulus(25, 1, 1, 1, 0, 1'b1, 32'd1);
        applyStimulus(6, 1, 0, 0, 2048, 1'b1, 32'd2);
        applyStimulus(14, 0, 1, 2, 3, 1'b1, 32'd3);
        applyStimulus(19, 5, 0, 0, 32'h12345001, 1'b1, 32'd2);
        drain();
        checkOutput("count_after_errors", 32'(count), 32'd2);

        issue(1, 7, 8, 9, 0);
        issue(16, 0, 3, 4, -4096);
        issue(6, 2, 3, 0, -2048);
        issue(10, 2, 3, 0, 2047);
        issue(18, 0, 0, 0, (1 << 20) - 2);
        issue(18, 0, 0, 0, 1 << 20);
        issue(17, 0, 1, 1, 4096);
        issue(13, 0, 1, 1, -2049);
        issue(20, 0, 0, 0, 0);
        issue(12, 1, 5, 0, 4);
        for (int k = 0; k < 20; k++)
            issue(k, (k + 1) % 32, (k + 3) % 32, (k + 7) % 32, (k == 19) ? 32'h000AB000 : 8 * k - 40);
        drain();

        if (m_cnt == DEPTH)
            doRestart();
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        op       = 5'd0;
        rd       = 5'd3;
        rs1      = 5'd1;
        rs2      = 5'd2;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_imem_we", 32'(imem_we), 32'd0);
        checkOutput("abort_imem_addr", 32'(imem_addr), 32'd0);
        checkOutput("abort_imem_wdata", imem_wdata, 32'd0);
        checkOutput("abort_count", 32'(count), 32'd0);
        checkOutput("abort_in_ready", 32'(in_ready), 32'd0);
        rst   = 1'b0;
        m_ptr = BASE;
        m_cnt = 0;
        repeat (3) @(negedge clk);
        applyStimulus(8, 4, 4, 0, 32'h7F, 1'b1, 32'h07F26213);
        drain();
        checkOutput("addr_after_abort", 32'(imem_addr), 32'(BASE));

        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/riscv_instr_encoder.md
# riscv_instr_encoder

- Sequential RISC-V RV32I instruction encoder and instruction-memory loader.
- Accepts one symbolic instruction per handshake: operation select, register fields and a 32-bit immediate.
- Range-checks the immediate, packs the 32-bit machine word in the formats the core's controller decodes (opcode, funct3, funct7), and writes it to consecutive word slots of instruction memory.
- Used by testbenches and boot loading to build programs for the single-cycle core.

## Interface

Parameters:
- ADDR_WIDTH, 8: instruction-memory byte-address width.
- DEPTH, 64: number of words the loader may write.
- BASE_ADDR, 0: byte address of the first word. Must be word-aligned, and BASE_ADDR + 4*DEPTH ≤ 2^ADDR_WIDTH.

Ports:
- clk  in  1  clock; single clock domain, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- restart  in  1  rewinds write pointer to BASE_ADDR; honored only in IDLE or DONE.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  encoder can accept.
- op  in  5  operation select (see Operation).
- rd, rs1, rs2  in  5 each  register indices; fields unused by a format are ignored.
- imm  in  32  signed immediate (byte offset for branch/jump; full upper value for LUI).
- imem_we  out  1  one-cycle memory write strobe.
- imem_addr  out  ADDR_WIDTH  byte address of the write.
- imem_wdata  out  32  encoded instruction.
- err  out  1  one-cycle pulse; instruction rejected.
- err_code  out  2  01 illegal op, 10 immediate out of range, 11 misaligned branch/jump offset.
- count  out  ADDR_WIDTH  words written since reset/restart.
- done  out  1  DEPTH words written.

## Operation

Op table (name: opcode, funct3, funct7):
- R-type, opcode 0110011:
  - 0 ADD: 000, 0000000
  - 1 SUB: 000, 0100000
  - 2 AND: 111
  - 3 OR: 110
  - 4 SLT: 010
  - 5 SLTU: 011
- I-type ALU, opcode 0010011:
  - 6 ADDI: 000
  - 7 XORI: 100
  - 8 ORI: 110
  - 9 SLTI: 010
  - 10 SLTIU: 011
- 11 LW: 0000011, 010
- 12 JALR: 1100111, 000
- 13 SW: 0100011, 010
- Branches, opcode 1100011:
  - 14 BEQ: 000
  - 15 BNE: 001
  - 16 BLT: 100
  - 17 BGE: 101
- 18 JAL: 1101111
- 19 LUI: 0110111
- 20–31: illegal.

Bit packing, MSB to LSB:
- R: funct7 | rs2 | rs1 | f3 | rd | op
- I: imm[11:0] | rs1 | f3 | rd | op
- S: imm[11:5] | rs2 | rs1 | f3 | imm[4:0] | op
- B: imm[12] | imm[10:5] | rs2 | rs1 | f3 | imm[4:1] | imm[11] | op
- J: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | op
- U: imm[31:12] | rd | op

Checks, in priority order:
- Illegal op.
- Range:
  - I/S: imm in −2048..2047.
  - B: imm in −4096..4095.
  - J: imm in −2^20..2^20−1.
  - U: imm[11:0] must be 0.
- Alignment: B/J imm[0] must be 0.
- The first failing check sets err_code.

FSM states:
- IDLE: in_ready = !restart.
  - restart → clear pointer and count, stay in IDLE.
  - in_valid & in_ready → capture fields, go to ENCODE.
- ENCODE: build the word and run the checks into registers; go to WRITE.
- WRITE:
  - If legal: imem_we=1, imem_addr=pointer, imem_wdata=word; then pointer += 4 and count += 1.
  - If rejected: err=1 with err_code, imem_we=0, pointer unchanged.
  - Next state is DONE if count reaches DEPTH, else IDLE.
- DONE: done=1, in_ready=0; restart → clear pointer, count and done, go to IDLE.

## Timing

- Reset: state IDLE; in_ready, imem_we, err, done = 0; err_code, imem_addr, imem_wdata, count = 0. in_ready rises the cycle after rst deasserts.
- Handshake accepted at edge N: imem_we/err asserted during cycle N+2, one cycle wide. Throughput is one instruction per 3 cycles.
- in_ready is 0 in ENCODE, WRITE, DONE and whenever restart is high.
- imem_addr/imem_wdata hold their last written values when imem_we=0.
- restart in ENCODE/WRITE is ignored.
- rst in any state aborts the operation: no write, pointer back to BASE_ADDR.
- The pointer never wraps. DONE blocks further writes.

## Test plan

- ADD rd=3 rs1=1 rs2=2 accepted at edge 0 → cycle 2: imem_we=1, addr=BASE_ADDR, wdata=0x002081B3; count=1.
- Back-to-back ADDI rd=1 rs1=0 imm=−1, then SW rs2=5 rs1=2 imm=8, then LUI rd=5 imm=0x12345000 → 0xFFF00093, 0x00512423, 0x123452B7 at BASE, BASE+4, BASE+8.
- BEQ rs1=1 rs2=2 imm=−4 → 0xFE208EE3; JAL rd=1 imm=8 → 0x008000EF.
- Error cases, each with imem_we=0 and pointer/count unchanged:
  - op=25 → err, err_code=01.
  - ADDI imm=2048 → err_code=10.
  - BEQ imm=3 → err_code=11.
  - LUI imm=0x12345001 → err_code=10.
- DEPTH=4: four legal writes → done=1, in_ready=0, and a fifth in_valid is not accepted. restart → count=0, next write at BASE_ADDR.
- rst asserted in ENCODE → no imem_we, all outputs at reset values, next accepted instruction written at BASE_ADDR.
